// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one req/ack data-bus transaction per
// memory op, stalling the pipeline until the access completes.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic [4:0]  wb_dest_addr,
    output logic        wb_we,
    output logic        align_err
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_is_mem;
    logic        w_is_load;
    logic        w_sext;
    logic [1:0]  w_sz;
    logic        w_misal;
    logic        w_accept;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic        w_stall;

    logic        r_is_load;
    logic        r_sext;
    logic [1:0]  r_sz;
    logic [1:0]  r_lane;
    logic [4:0]  r_dest;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;
    logic        r_done;
    logic [31:0] r_load_data;
    logic [4:0]  r_wb_dest;
    logic        r_wb_we;
    logic        r_align_err;

    // Opcode decode; unknown codes behave as "none".
    always_comb begin
        w_is_mem  = 1'b0;
        w_is_load = 1'b0;
        w_sext    = 1'b0;
        w_sz      = SZ_W;
        case (op_code)
            4'd1: begin
                w_is_mem = 1'b1; w_is_load = 1'b1;
                w_sext = 1'b1; w_sz = SZ_B;
            end
            4'd2: begin
                w_is_mem = 1'b1; w_is_load = 1'b1;
                w_sz = SZ_B;
            end
            4'd3: begin
                w_is_mem = 1'b1; w_is_load = 1'b1;
                w_sext = 1'b1; w_sz = SZ_H;
            end
            4'd4: begin
                w_is_mem = 1'b1; w_is_load = 1'b1;
                w_sz = SZ_H;
            end
            4'd5: begin
                w_is_mem = 1'b1; w_is_load = 1'b1;
                w_sz = SZ_W;
            end
            4'd8: begin
                w_is_mem = 1'b1; w_sz = SZ_B;
            end
            4'd9: begin
                w_is_mem = 1'b1; w_sz = SZ_H;
            end
            4'd10: begin
                w_is_mem = 1'b1; w_sz = SZ_W;
            end
            default: begin
                w_is_mem = 1'b0;
            end
        endcase
    end

    assign w_accept = op_valid & w_is_mem;
    assign w_misal  = ((w_sz == SZ_H) & addr[0])
                    | ((w_sz == SZ_W) & (addr[1:0] != 2'b00));

    // Big-endian lane enables and store-data replication.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = store_data;
        case (w_sz)
            SZ_B: begin
                w_sel   = 4'b1000 >> addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                w_sel   = addr[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Lane extraction and extension of the returned word.
    always_comb begin
        w_byte = bus_rdata[31:24];
        case (r_lane)
            2'd0: w_byte = bus_rdata[31:24];
            2'd1: w_byte = bus_rdata[23:16];
            2'd2: w_byte = bus_rdata[15:8];
            default: w_byte = bus_rdata[7:0];
        endcase
        w_half = r_lane[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        w_ext  = bus_rdata;
        case (r_sz)
            SZ_B: w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
            SZ_H: w_ext = {{16{r_sext & w_half[15]}}, w_half};
            default: w_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_misal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall drops in DONE so the pipeline advances at the end of that cycle.
    always_comb begin
        w_stall = 1'b0;
        if (!rst && w_accept && (r_state != S_DONE)) begin
            w_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load   <= 1'b0;
            r_sext      <= 1'b0;
            r_sz        <= SZ_W;
            r_lane      <= 2'b00;
            r_dest      <= 5'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_sel   <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_done      <= 1'b0;
            r_load_data <= 32'd0;
            r_wb_dest   <= 5'd0;
            r_wb_we     <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_wb_we     <= 1'b0;
            r_align_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_load <= w_is_load;
                        r_sext    <= w_sext;
                        r_sz      <= w_sz;
                        r_lane    <= addr[1:0];
                        r_dest    <= dest_addr;
                        if (w_misal) begin
                            r_done      <= 1'b1;
                            r_align_err <= 1'b1;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= ~w_is_load;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_sel   <= w_sel;
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        if (r_is_load) begin
                            r_load_data <= w_ext;
                            r_wb_we     <= 1'b1;
                            r_wb_dest   <= r_dest;
                        end
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_sel      = r_bus_sel;
    assign bus_wdata    = r_bus_wdata;
    assign stall        = w_stall;
    assign done         = r_done;
    assign load_data    = r_load_data;
    assign wb_dest_addr = r_wb_dest;
    assign wb_we        = r_wb_we;
    assign align_err    = r_align_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, multi-cycle corner
// sequences and random ops against a byte-lane reference model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op_code;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  dest_addr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic [4:0]  wb_dest_addr;
    logic        wb_we;
    logic        align_err;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_code(op_code),
        .addr(addr), .store_data(store_data),
        .dest_addr(dest_addr),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .stall(stall),
        .done(done), .load_data(load_data),
        .wb_dest_addr(wb_dest_addr), .wb_we(wb_we),
        .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [4:0]  d;
        logic [31:0] rd;
        int          waits;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic        bwe;
        logic [31:0] ld;
        logic        wbwe;
        logic        err;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_ld = 32'd0;

    int   n_rise = 0;
    int   n_done = 0;
    logic prev_req = 1'b0;

    always @(posedge clk) begin
        prev_req <= bus_req;
        if (bus_req && !prev_req) n_rise <= n_rise + 1;
        if (done) n_done <= n_done + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-lane arithmetic on a big-endian word.
    function automatic vec_t model(input vec_t vin);
        vec_t v;
        int unsigned k, sz, sh;
        logic is_ld, sx;
        logic [31:0] mask, f;
        v = vin;
        k = v.a % 4;
        sz = 4; is_ld = 1'b0; sx = 1'b0;
        case (v.op)
            4'd1: begin sz = 1; is_ld = 1; sx = 1; end
            4'd2: begin sz = 1; is_ld = 1; end
            4'd3: begin sz = 2; is_ld = 1; sx = 1; end
            4'd4: begin sz = 2; is_ld = 1; end
            4'd5: begin sz = 4; is_ld = 1; end
            4'd8: sz = 1;
            4'd9: sz = 2;
            default: sz = 4;
        endcase
        v.err  = (v.a % sz) != 0;
        v.bwe  = !is_ld;
        v.wbwe = is_ld && !v.err;
        v.sel  = 4'hF;
        v.ld   = 32'd0;
        if (!v.err) begin
            if (sz == 1) v.sel = 4'(1 << (3 - k));
            else if (sz == 2) v.sel = 4'(3 << (2 - k));
            mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
            sh = 8 * (4 - sz - k);
            f = (v.rd >> sh) & mask;
            v.ld = (sx && f[8 * sz - 1]) ? (f | ~mask) : f;
        end
        if (sz == 1) v.wd = {24'd0, v.sd[7:0]} * 32'h0101_0101;
        else if (sz == 2) v.wd = {16'd0, v.sd[15:0]} * 32'h0001_0001;
        else v.wd = v.sd;
        return v;
    endfunction

    // Drives one op from IDLE through DONE; returns in the DONE cycle.
    task automatic do_op(input vec_t v);
        @(negedge clk);
        op_valid = 1'b1; op_code = v.op; addr = v.a;
        store_data = v.sd; dest_addr = v.d;
        bus_ack = 1'b0; bus_rdata = ~v.rd;
        #1;
        chk("stall_accept", stall, 1);
        chk("req_accept", bus_req, 0);
        if (!v.err) begin
            for (int w = 0; w <= v.waits; w++) begin
                @(negedge clk);
                bus_ack = (w == v.waits);
                bus_rdata = (w == v.waits) ? v.rd : $urandom;
                #1;
                chk("req_wait", bus_req, 1);
                chk("stall_wait", stall, 1);
                chk("bus_we", bus_we, v.bwe);
                chk("bus_addr", bus_addr, {v.a[31:2], 2'b00});
                chk("bus_sel", bus_sel, v.sel);
                if (v.bwe) chk("bus_wdata", bus_wdata, v.wd);
            end
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom;
        if (v.wbwe) m_ld = v.ld;
        #1;
        chk("done", done, 1);
        chk("stall_done", stall, 0);
        chk("req_done", bus_req, 0);
        chk("wb_we", wb_we, v.wbwe);
        chk("align_err", align_err, v.err);
        chk("load_data", load_data, m_ld);
        if (v.wbwe) chk("wb_dest", wb_dest_addr, v.d);
    endtask

    vec_t vec[12];
    vec_t rv;
    int   r0, d0;
    logic [3:0] ops[8];

    initial begin
        //        op     addr          sd            d   rd            w  sel    wd            bwe ld            wbwe err
        vec[0]  = '{4'd5,  32'h100, 32'h0,        5'd7,  32'hDEADBEEF, 0, 4'hF, 32'h0,        0, 32'hDEADBEEF, 1, 0};
        vec[1]  = '{4'd1,  32'h103, 32'h0,        5'd3,  32'h000000F0, 0, 4'h1, 32'h0,        0, 32'hFFFFFFF0, 1, 0};
        vec[2]  = '{4'd2,  32'h103, 32'h0,        5'd4,  32'h000000F0, 0, 4'h1, 32'h0,        0, 32'h000000F0, 1, 0};
        vec[3]  = '{4'd9,  32'h202, 32'h1234ABCD, 5'd0,  32'h0,        3, 4'h3, 32'hABCDABCD, 1, 32'h0,        0, 0};
        vec[4]  = '{4'd5,  32'h102, 32'h0,        5'd9,  32'h0,        0, 4'hF, 32'h0,        0, 32'h0,        0, 1};
        vec[5]  = '{4'd3,  32'h200, 32'h0,        5'd10, 32'h80017F00, 1, 4'hC, 32'h0,        0, 32'hFFFF8001, 1, 0};
        vec[6]  = '{4'd4,  32'h202, 32'h0,        5'd11, 32'h80017F00, 0, 4'h3, 32'h0,        0, 32'h00007F00, 1, 0};
        vec[7]  = '{4'd8,  32'h101, 32'h000000A5, 5'd0,  32'h0,        2, 4'h4, 32'hA5A5A5A5, 1, 32'h0,        0, 0};
        vec[8]  = '{4'd10, 32'h300, 32'h11223344, 5'd0,  32'h0,        1, 4'hF, 32'h11223344, 1, 32'h0,        0, 0};
        vec[9]  = '{4'd3,  32'h201, 32'h0,        5'd12, 32'h0,        0, 4'hF, 32'h0,        0, 32'h0,        0, 1};
        vec[10] = '{4'd1,  32'h100, 32'h0,        5'd31, 32'h7F000000, 0, 4'h8, 32'h0,        0, 32'h0000007F, 1, 0};
        vec[11] = '{4'd9,  32'h305, 32'h5555AAAA, 5'd0,  32'h0,        0, 4'hF, 32'h0,        1, 32'h0,        0, 1};
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

        rst = 1'b1; op_valid = 1'b1; op_code = 4'd5;
        addr = 32'h100; store_data = 32'h0; dest_addr = 5'd1;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_sel", bus_sel, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_wbd", wb_dest_addr, 0);
        chk("rst_wbwe", wb_we, 0);
        chk("rst_err", align_err, 0);
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;

        foreach (vec[i]) do_op(vec[i]);

        // Reset in the second REQ cycle, then a stray ack.
        @(negedge clk);
        op_valid = 1'b1; op_code = 4'd5; addr = 32'h400; dest_addr = 5'd5;
        @(negedge clk);
        #1 chk("mid_req1", bus_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        m_ld = 32'd0;
        #1;
        chk("mid_req", bus_req, 0);
        chk("mid_done", done, 0);
        chk("mid_ld", load_data, 0);
        chk("mid_sel", bus_sel, 0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("stray_done", done, 0);
        chk("stray_wbwe", wb_we, 0);
        chk("stray_req", bus_req, 0);
        rv = '{4'd5, 32'h400, 32'h0, 5'd5, 32'h13579BDF, 1,
               4'hF, 32'h0, 0, 32'h0, 0, 0};
        do_op(model(rv));

        // Back-to-back SBs with op_valid held throughout.
        @(posedge clk); #1;
        r0 = n_rise; d0 = n_done;
        rv = '{4'd8, 32'h10, 32'h11, 5'd0, 32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0};
        do_op(model(rv));
        rv.a = 32'h13; rv.sd = 32'h22; rv.waits = 1;
        do_op(model(rv));
        @(posedge clk); #1;
        chk("b2b_req_rises", n_rise - r0, 2);
        chk("b2b_done_pulses", n_done - d0, 2);

        // Non-memory codes and op_valid=0 never stall or touch the bus.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            op_valid = (i != 5);
            op_code = (i == 5) ? 4'd5 : 4'((i * 3 + (i > 0 ? 3 : 0)) % 16);
            if (op_code inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10}
                && i != 5)
                op_code = 4'd0;
            #1;
            chk("none_stall", stall, 0);
            chk("none_req", bus_req, 0);
            chk("none_done", done, 0);
        end
        @(negedge clk);
        op_valid = 1'b0;
        #1 chk("none_req_after", bus_req, 0);

        for (int n = 0; n < 40; n++) begin
            rv.op = ops[$urandom_range(0, 7)];
            rv.a = $urandom;
            if ($urandom_range(0, 1) == 1) rv.a[1:0] = 2'b00;
            rv.sd = $urandom;
            rv.d = 5'($urandom);
            rv.rd = $urandom;
            rv.waits = $urandom_range(0, 3);
            do_op(model(rv));
        end

        @(negedge clk);
        op_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
